// File: rtl/datapath_step_sequencer.sv
// datapath_step_sequencer
//   Program-buffer driven control sequencer for a simple datapath. Fetches
//   16-bit instructions from a small writable buffer and walks them through
//   FETCH / EXEC / MEM / WB states, producing registered (Moore) control
//   fields for the register file, ALU and data memory.
//
//   Instruction word: [15:12] opcode, [11:8] rdest, [7:0] imm, [3:0] rsrc.
//   Opcodes: 0 LI, 1 ADD, 2 STORE, 3 LOAD, F HALT, anything else NOP.
//
//   Build option: define DATAPATH_SEQ_STEP_EN to compile in the push-button
//   step synchronizer and run_mode gating. Without it, step and run_mode are
//   ignored and the sequencer advances every cycle.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high; clears all state except the buffer
//   step          raw push-button, active-low, asynchronous to clk
//   run_mode      1 = free-run, 0 = one state per step press
//   start         pulse; leaves IDLE/HALT and restarts at pc=0
//   prog_we       program buffer write enable (honoured only in IDLE/HALT)
//   prog_addr     program buffer write address
//   prog_data     program word
//   inst          latched current instruction
//   reg_write     register file write strobe
//   reg_write_src 0 = ALU result, 1 = memory data
//   alu_A_src     0 = zero, 1 = register rdest
//   alu_B_src     0 = register rsrc, 1 = immediate
//   alu_cont      ALU operation
//   mem_addr      data memory address
//   mem_write     data memory write strobe
//   pc            program counter
//   state         current state code
//   halted        high while in HALT
module datapath_step_sequencer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 8,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              run_mode,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PW-1:0]     prog_addr,
    input  logic [15:0]       prog_data,
    output logic [15:0]       inst,
    output logic              reg_write,
    output logic              reg_write_src,
    output logic              alu_A_src,
    output logic [1:0]        alu_B_src,
    output logic [4:0]        alu_cont,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [PW-1:0]     pc,
    output logic [2:0]        state,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [3:0] OP_LI    = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t          cur_state, nxt_state;
    logic [PW-1:0]   pc_q, nxt_pc;
    logic [15:0]     inst_q, nxt_inst;
    logic [15:0]     prog_buf [DEPTH];
    logic            advance;

    // Control fields for the state being entered; registered below so all
    // outputs change together with the state.
    logic              d_reg_write, d_reg_write_src, d_alu_A_src, d_mem_write;
    logic [1:0]        d_alu_B_src;
    logic [4:0]        d_alu_cont;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [3:0]        nxt_op;

`ifdef DATAPATH_SEQ_STEP_EN
    // Two-flop synchronizer plus one delay flop for the falling-edge detect.
    // Idle level of the button is high, so reset to 1 to avoid a false press.
    logic step_s1, step_s2, step_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_s1 <= 1'b1;
            step_s2 <= 1'b1;
            step_s3 <= 1'b1;
        end else begin
            step_s1 <= step;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
        end
    end

    assign advance = run_mode | (step_s3 & ~step_s2);
`else
    logic unused_inputs;
    assign unused_inputs = ^{step, run_mode};
    assign advance       = 1'b1;
`endif

    // Program buffer: not reset; writes only while the sequencer is parked.
    always_ff @(posedge clk) begin
        if (prog_we && (cur_state == S_IDLE || cur_state == S_HALT)) begin
            prog_buf[prog_addr] <= prog_data;
        end
    end

    // Next-state, next-pc, next-instruction. start from IDLE/HALT does not
    // depend on advance.
    always_comb begin
        nxt_state = cur_state;
        nxt_pc    = pc_q;
        nxt_inst  = inst_q;
        unique case (cur_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    nxt_state = S_FETCH;
                    nxt_pc    = '0;
                end
            end
            S_FETCH: begin
                if (advance) begin
                    nxt_inst  = prog_buf[pc_q];
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (advance) begin
                    case (inst_q[15:12])
                        OP_HALT:           nxt_state = S_HALT;
                        OP_STORE, OP_LOAD: nxt_state = S_MEM;
                        OP_LI, OP_ADD:     nxt_state = S_WB;
                        default: begin
                            nxt_state = S_FETCH;
                            nxt_pc    = pc_q + PW'(1);
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (advance) begin
                    if (inst_q[15:12] == OP_LOAD) begin
                        nxt_state = S_WB;
                    end else begin
                        nxt_state = S_FETCH;
                        nxt_pc    = pc_q + PW'(1);
                    end
                end
            end
            S_WB: begin
                if (advance) begin
                    nxt_state = S_FETCH;
                    nxt_pc    = pc_q + PW'(1);
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Moore decode of the upcoming state/instruction.
    always_comb begin
        d_reg_write     = 1'b0;
        d_reg_write_src = 1'b0;
        d_alu_A_src     = 1'b0;
        d_alu_B_src     = 2'd0;
        d_alu_cont      = 5'd0;
        d_mem_addr      = '0;
        d_mem_write     = 1'b0;
        nxt_op          = nxt_inst[15:12];
        if (nxt_state == S_EXEC || nxt_state == S_MEM || nxt_state == S_WB) begin
            case (nxt_op)
                OP_LI: begin
                    d_alu_B_src = 2'd1;
                    d_alu_cont  = 5'b01000;
                end
                OP_ADD: begin
                    d_alu_A_src = 1'b1;
                    d_alu_cont  = 5'b00011;
                end
                OP_STORE, OP_LOAD: begin
                    d_alu_A_src = 1'b1;
                    d_alu_B_src = 2'd1;
                    d_alu_cont  = 5'b00011;
                    d_mem_addr  = ADDR_W'(nxt_inst[7:0]);
                end
                default: ;
            endcase
            d_mem_write     = (nxt_state == S_MEM) && (nxt_op == OP_STORE);
            d_reg_write     = (nxt_state == S_WB);
            d_reg_write_src = (nxt_state == S_WB) && (nxt_op == OP_LOAD);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state     <= S_IDLE;
            pc_q          <= '0;
            inst_q        <= '0;
            reg_write     <= 1'b0;
            reg_write_src <= 1'b0;
            alu_A_src     <= 1'b0;
            alu_B_src     <= 2'd0;
            alu_cont      <= 5'd0;
            mem_addr      <= '0;
            mem_write     <= 1'b0;
            halted        <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            pc_q          <= nxt_pc;
            inst_q        <= nxt_inst;
            reg_write     <= d_reg_write;
            reg_write_src <= d_reg_write_src;
            alu_A_src     <= d_alu_A_src;
            alu_B_src     <= d_alu_B_src;
            alu_cont      <= d_alu_cont;
            mem_addr      <= d_mem_addr;
            mem_write     <= d_mem_write;
            halted        <= (nxt_state == S_HALT);
        end
    end

    assign state = cur_state;
    assign pc    = pc_q;
    assign inst  = inst_q;

endmodule

// File: tb/tb_datapath_step_sequencer.sv
module tb_datapath_step_sequencer;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset, step, run_mode, start, prog_we;
    logic [2:0]  prog_addr;
    logic [15:0] prog_data;
    logic [15:0] inst;
    logic        reg_write, reg_write_src, alu_A_src, mem_write, halted;
    logic [1:0]  alu_B_src;
    logic [4:0]  alu_cont;
    logic [7:0]  mem_addr;
    logic [2:0]  pc, state;

    always #5 clk = ~clk;

    datapath_step_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .step(step), .run_mode(run_mode),
        .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .inst(inst), .reg_write(reg_write),
        .reg_write_src(reg_write_src), .alu_A_src(alu_A_src),
        .alu_B_src(alu_B_src), .alu_cont(alu_cont), .mem_addr(mem_addr),
        .mem_write(mem_write), .pc(pc), .state(state), .halted(halted)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: program image, last latched instruction, expected trace.
    typedef logic [41:0] rec_t;
    logic [15:0] prog [DEPTH];
    logic [15:0] last_inst;
    rec_t        exp_q[$];

    // Expected output record for one cycle spent in state st.
    function automatic rec_t mk(input logic [2:0] st, input logic [2:0] p, input logic [15:0] ins);
        logic rw, rws, as_, mw;
        logic [1:0] bs;
        logic [4:0] c;
        logic [7:0] ma;
        logic [3:0] op;
        rw = 0; rws = 0; as_ = 0; mw = 0; bs = 0; c = 0; ma = 0;
        op = ins[15:12];
        if (st == 3'd2 || st == 3'd3 || st == 3'd4) begin
            if (op == 4'h0) begin bs = 2'd1; c = 5'b01000; end
            if (op == 4'h1) begin as_ = 1; c = 5'b00011; end
            if (op == 4'h2 || op == 4'h3) begin as_ = 1; bs = 2'd1; c = 5'b00011; ma = ins[7:0]; end
            mw  = (st == 3'd3) && (op == 4'h2);
            rw  = (st == 3'd4);
            rws = (st == 3'd4) && (op == 4'h3);
        end
        return {st, p, ins, rw, rws, as_, bs, c, ma, mw, (st == 3'd5)};
    endfunction

    function automatic rec_t obs_rec();
        return {state, pc, inst, reg_write, reg_write_src, alu_A_src, alu_B_src,
                alu_cont, mem_addr, mem_write, halted};
    endfunction

    // Instruction-level walk of the program: each instruction contributes
    // FETCH, EXEC and its optional MEM / WB cycles.
    task automatic build_trace(input int max_cycles);
        int p;
        logic [15:0] w;
        logic [3:0] op;
        p = 0;
        exp_q.delete();
        while (exp_q.size() < max_cycles) begin
            w = prog[p];
            op = w[15:12];
            exp_q.push_back(mk(3'd1, 3'(p), last_inst));
            last_inst = w;
            exp_q.push_back(mk(3'd2, 3'(p), w));
            if (op == 4'hF) begin
                exp_q.push_back(mk(3'd5, 3'(p), w));
                break;
            end
            if (op == 4'h2 || op == 4'h3) exp_q.push_back(mk(3'd3, 3'(p), w));
            if (op == 4'h0 || op == 4'h1 || op == 4'h3) exp_q.push_back(mk(3'd4, 3'(p), w));
            p = (p + 1) % DEPTH;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        reset = 1; start = 0; prog_we = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        last_inst = 16'h0;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_we = 1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 0;
        prog[a] = d;
    endtask

    // Pulse start, then compare every cycle against exp_q. Optionally drives
    // a program write at trace index inj_idx (model not updated).
    task automatic run_compare(input string tag, input int inj_idx, input logic [2:0] inj_a,
                               input logic [15:0] inj_d, output int rw_cnt, output int mw_cnt,
                               output int halt_idx);
        rw_cnt = 0; mw_cnt = 0; halt_idx = -1;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), 64'(obs_rec()), 64'(exp_q[i]));
            if (reg_write) rw_cnt++;
            if (mem_write) mw_cnt++;
            if (halted && halt_idx < 0) halt_idx = i;
            if (i == inj_idx) begin
                prog_we = 1; prog_addr = inj_a; prog_data = inj_d;
            end else begin
                prog_we = 0;
            end
            @(negedge clk);
        end
        prog_we = 0;
    endtask

`ifdef DATAPATH_SEQ_STEP_EN
    task automatic press(input string tag, input logic [2:0] before, input logic [2:0] after);
        @(negedge clk); #2 step = 0;
        @(posedge clk); @(posedge clk); #1;
        check({tag, "_pre"}, 64'(state), 64'(before));
        @(posedge clk); #1;
        check({tag, "_post"}, 64'(state), 64'(after));
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rw_c, mw_c, h_idx, k;
        logic [15:0] w;
        logic [3:0] ops [10];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3; ops[4] = 4'h5;
        ops[5] = 4'h9; ops[6] = 4'hF; ops[7] = 4'h0; ops[8] = 4'h3; ops[9] = 4'h1;

        reset = 1; step = 1; run_mode = 1; start = 0; prog_we = 0;
        prog_addr = 0; prog_data = 0; last_inst = 0;
        for (int i = 0; i < DEPTH; i++) prog[i] = 16'h0;

        // Reset state
        do_reset();
        check("reset_rec", 64'(obs_rec()), 64'(mk(3'd0, 3'd0, 16'h0)));

        // Reference program, free-running
        write_word(0, 16'h0103); write_word(1, 16'h0202); write_word(2, 16'h1102);
        write_word(3, 16'h2104); write_word(4, 16'hF000);
        last_inst = 0;
        build_trace(40);
        run_compare("prog_run", -1, 0, 0, rw_c, mw_c, h_idx);
        check("prog_halt_cycle", 64'(h_idx), 64'd14);
        check("prog_reg_write_cnt", 64'(rw_c), 64'd3);
        check("prog_mem_write_cnt", 64'(mw_c), 64'd1);

        // Write during EXEC ignored; write in HALT taken; LOAD sequence
        do_reset();
        write_word(0, 16'h0103); write_word(1, 16'hF000);
        last_inst = 0;
        build_trace(20);
        run_compare("wr_exec", 1, 3'd0, 16'h1234, rw_c, mw_c, h_idx);
        build_trace(20);
        run_compare("wr_exec_reread", -1, 0, 0, rw_c, mw_c, h_idx);
        write_word(0, 16'h3309);
        build_trace(20);
        run_compare("load_after_halt_wr", -1, 0, 0, rw_c, mw_c, h_idx);
        check("load_reg_write_cnt", 64'(rw_c), 64'd1);

        // Reset before entering MEM of a STORE: strobe never rises
        do_reset();
        write_word(0, 16'h2104); write_word(1, 16'hF000);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        check("rst_pre_state", 64'(state), 64'd2);
        reset = 1;
        #1 check("rst_exec_rec", 64'(obs_rec()), 64'(mk(3'd0, 3'd0, 16'h0)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_exec_hold", 64'({state, mem_write}), 64'd0);
        end
        reset = 0;

        // Reset while in MEM: asynchronous clear
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); @(negedge clk);
        check("rst_mem_pre", 64'({state, mem_write}), 64'({3'd3, 1'b1}));
        reset = 1;
        #1 check("rst_mem_rec", 64'(obs_rec()), 64'(mk(3'd0, 3'd0, 16'h0)));
        @(negedge clk);
        check("rst_mem_hold", 64'(obs_rec()), 64'(mk(3'd0, 3'd0, 16'h0)));
        reset = 0;

        // Randomized programs, including wrap past DEPTH-1
        for (int r = 0; r < 10; r++) begin
            do_reset();
            for (int a = 0; a < DEPTH; a++) begin
                w = 16'($urandom);
                w[15:12] = ops[$urandom_range(0, 9)];
                if (r == 0) w = 16'h7000;
                write_word(3'(a), w);
            end
            last_inst = 0;
            build_trace(30);
            run_compare($sformatf("rand%0d", r), -1, 0, 0, rw_c, mw_c, h_idx);
        end

`ifdef DATAPATH_SEQ_STEP_EN
        // Single-step mode
        do_reset();
        write_word(0, 16'h0103); write_word(1, 16'h0202); write_word(2, 16'h1102);
        write_word(3, 16'h2104); write_word(4, 16'hF000);
        run_mode = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check("step_start", 64'(state), 64'd1);
        repeat (6) @(negedge clk);
        check("step_no_press", 64'(state), 64'd1);
        press("step_p1", 3'd1, 3'd2);
        repeat (6) @(negedge clk);
        check("step_held", 64'(state), 64'd2);
        step = 1;
        repeat (4) @(negedge clk);
        check("step_release", 64'(state), 64'd2);
        press("step_p2", 3'd2, 3'd4);
        step = 1;
        repeat (4) @(negedge clk);
        press("step_p3", 3'd4, 3'd1);
        check("step_pc", 64'(pc), 64'd1);
        step = 1;
        run_mode = 1;
        k = 0;
        while (!halted && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("step_to_run_halt", 64'({halted, pc}), 64'({1'b1, 3'd4}));
`else
        // Without the step option run_mode is ignored
        do_reset();
        write_word(0, 16'h0103); write_word(1, 16'hF000);
        run_mode = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        check("norun_advances", 64'(state), 64'd2);
        run_mode = 1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
